riscv_processor: RTL and testbench

Five-stage in-order pipelined RV32I-subset CPU core (IF, ID, EX, MEM, WB) with internal instruction and data memories. It is the top level of the pipelined processor. It runs code preloaded into instruction memory from address 0 after reset. Hazards are resolved with forwarding, load-use stalls and branch flushes, so any legal instruction sequence executes correctly without software NOPs.

---
 rtl/riscv_processor.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_riscv_processor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_processor.sv
// riscv_processor: five-stage in-order RV32I-subset core (IF, ID, EX, MEM, WB)
// with internal 1024-word instruction and data memories. Code runs from
// address 0 after reset. Forwarding, a one-cycle load-use stall and a
// two-cycle flush on taken branches/jumps keep any legal sequence correct.
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous active-high reset

package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    // All-zero value of this struct is a bubble (no write, no redirect).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_beq;
        logic        is_bne;
        logic        is_jal;
        logic        is_jalr;
    } id_ex_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// Instruction memory: combinational read, optional synchronous write port.
module riscv_imem (
    input  logic        clk,
    input  logic        we_i,
    input  logic [9:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [9:0]  raddr_i,
    output logic [31:0] rdata_o
);
    logic [31:0] mem [0:1023];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// Fetch: PC register and instruction memory read.
module riscv_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    logic [31:0] pc;
    logic [31:0] pc_d;

    // Redirect outranks stall.
    always_comb begin
        if (redirect_i)   pc_d = target_i;
        else if (stall_i) pc_d = pc;
        else              pc_d = pc + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= '0;
        else     pc <= pc_d;
    end

    // The write port is unused in operation; contents are preloaded.
    riscv_imem imem (
        .clk     (clk),
        .we_i    (1'b0),
        .waddr_i (10'd0),
        .wdata_i (32'd0),
        .raddr_i (pc[11:2]),
        .rdata_o (instr_o)
    );

    assign pc_o = pc;
endmodule

// IF/ID pipeline register.
module riscv_if_id import riscv_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_out <= NOP_INSTR;
            pc_o            <= '0;
        end else if (flush_i) begin
            instruction_out <= NOP_INSTR;
            pc_o            <= '0;
        end else if (!hold_i) begin
            instruction_out <= instr_i;
            pc_o            <= pc_i;
        end
    end
endmodule

// Register file: two read ports, one write port, write-to-read bypass.
module riscv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            registers[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        if (raddr1_i == 5'd0)                       rdata1_o = '0;
        else if (we_i && (waddr_i == raddr1_i))     rdata1_o = wdata_i;
        else                                        rdata1_o = registers[raddr1_i];
        if (raddr2_i == 5'd0)                       rdata2_o = '0;
        else if (we_i && (waddr_i == raddr2_i))     rdata2_o = wdata_i;
        else                                        rdata2_o = registers[raddr2_i];
    end
endmodule

// Decode: control generation, immediates, register reads.
module riscv_decode import riscv_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output id_ex_t      ctrl_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o
);
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [31:0] rd1, rd2;
    id_ex_t      c;
    logic        valid, u1, u2;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    riscv_regfile reg_file (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (instr_i[19:15]),
        .raddr2_i (instr_i[24:20]),
        .we_i     (wb_we_i),
        .waddr_i  (wb_rd_i),
        .wdata_i  (wb_data_i),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    always_comb begin
        c         = '0;
        valid     = 1'b1;
        u1        = 1'b0;
        u2        = 1'b0;
        c.pc      = pc_i;
        c.rs1_val = rd1;
        c.rs2_val = rd2;
        c.rs1     = instr_i[19:15];
        c.rs2     = instr_i[24:20];
        c.rd      = instr_i[11:7];
        case (opcode)
            7'b0110011: begin
                c.reg_write = 1'b1;
                u1 = 1'b1;
                u2 = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'b000}: c.alu_op = ALU_ADD;
                    {7'h20, 3'b000}: c.alu_op = ALU_SUB;
                    {7'h00, 3'b111}: c.alu_op = ALU_AND;
                    {7'h00, 3'b110}: c.alu_op = ALU_OR;
                    {7'h00, 3'b100}: c.alu_op = ALU_XOR;
                    {7'h00, 3'b001}: c.alu_op = ALU_SLL;
                    {7'h00, 3'b101}: c.alu_op = ALU_SRL;
                    {7'h20, 3'b101}: c.alu_op = ALU_SRA;
                    {7'h00, 3'b010}: c.alu_op = ALU_SLT;
                    {7'h00, 3'b011}: c.alu_op = ALU_SLTU;
                    default:         valid = 1'b0;
                endcase
            end
            7'b0010011: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm       = imm_i;
                u1 = 1'b1;
                case (f3)
                    3'b000: c.alu_op = ALU_ADD;
                    3'b111: c.alu_op = ALU_AND;
                    3'b110: c.alu_op = ALU_OR;
                    3'b100: c.alu_op = ALU_XOR;
                    3'b010: c.alu_op = ALU_SLT;
                    3'b011: c.alu_op = ALU_SLTU;
                    3'b001: begin
                        if (f7 == 7'h00) c.alu_op = ALU_SLL;
                        else             valid = 1'b0;
                    end
                    default: begin
                        if (f7 == 7'h00)      c.alu_op = ALU_SRL;
                        else if (f7 == 7'h20) c.alu_op = ALU_SRA;
                        else                  valid = 1'b0;
                    end
                endcase
            end
            7'b0000011: begin
                valid       = (f3 == 3'b010);
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src   = 1'b1;
                c.imm       = imm_i;
                u1 = 1'b1;
            end
            7'b0100011: begin
                valid       = (f3 == 3'b010);
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm       = imm_s;
                u1 = 1'b1;
                u2 = 1'b1;
            end
            7'b1100011: begin
                valid    = (f3 == 3'b000) || (f3 == 3'b001);
                c.is_beq = (f3 == 3'b000);
                c.is_bne = (f3 == 3'b001);
                c.imm    = imm_b;
                u1 = 1'b1;
                u2 = 1'b1;
            end
            7'b1101111: begin
                c.is_jal    = 1'b1;
                c.reg_write = 1'b1;
                c.imm       = imm_j;
            end
            7'b1100111: begin
                valid       = (f3 == 3'b000);
                c.is_jalr   = 1'b1;
                c.reg_write = 1'b1;
                c.imm       = imm_i;
                u1 = 1'b1;
            end
            default: valid = 1'b0;
        endcase
        // Unused source fields are cleared so they never trigger forwarding
        // or a false load-use stall.
        if (!u1) c.rs1 = '0;
        if (!u2) c.rs2 = '0;
        if (!valid) begin
            c  = '0;
            u1 = 1'b0;
            u2 = 1'b0;
        end
        ctrl_o     = c;
        uses_rs1_o = u1;
        uses_rs2_o = u2;
    end
endmodule

// Execute: operand forwarding, ALU, branch resolution.
module riscv_execute import riscv_pkg::*; (
    input  id_ex_t      ex_i,
    input  logic        exm_we_i,
    input  logic [4:0]  exm_rd_i,
    input  logic [31:0] exm_data_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] alu_result,
    output logic        branch_taken,
    output logic [31:0] jump_target,
    output logic [31:0] result_o,
    output logic [31:0] store_data_o
);
    logic [31:0] op_a, op_b_reg, op_b;

    // The younger producer (EX/MEM) wins over MEM/WB.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf_val,
                                        input logic em_we, input logic [4:0] em_rd,
                                        input logic [31:0] em_data, input logic mw_we,
                                        input logic [4:0] mw_rd, input logic [31:0] mw_data);
        if ((src != 5'd0) && em_we && (em_rd == src))      return em_data;
        else if ((src != 5'd0) && mw_we && (mw_rd == src)) return mw_data;
        else                                               return rf_val;
    endfunction

    always_comb begin
        op_a     = fwd(ex_i.rs1, ex_i.rs1_val, exm_we_i, exm_rd_i, exm_data_i, wb_we_i, wb_rd_i, wb_data_i);
        op_b_reg = fwd(ex_i.rs2, ex_i.rs2_val, exm_we_i, exm_rd_i, exm_data_i, wb_we_i, wb_rd_i, wb_data_i);
        op_b     = ex_i.alu_src ? ex_i.imm : op_b_reg;
        case (ex_i.alu_op)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SLL:  alu_result = op_a << op_b[4:0];
            ALU_SRL:  alu_result = op_a >> op_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {31'd0, op_a < op_b};
            default:  alu_result = '0;
        endcase
        branch_taken = (ex_i.is_beq && (op_a == op_b_reg)) || (ex_i.is_bne && (op_a != op_b_reg))
                       || ex_i.is_jal || ex_i.is_jalr;
        jump_target  = ex_i.is_jalr ? ((op_a + ex_i.imm) & ~32'd1) : (ex_i.pc + ex_i.imm);
        result_o     = (ex_i.is_jal || ex_i.is_jalr) ? (ex_i.pc + 32'd4) : alu_result;
        store_data_o = op_b_reg;
    end
endmodule

// Top level.
module riscv_processor import riscv_pkg::*; (
    input logic clk,
    input logic rst
);
    logic [31:0] if_pc, if_instr, id_instr, id_pc;
    logic        redirect, load_use, stall;
    logic        uses_rs1, uses_rs2;
    id_ex_t      dec_ctrl, id_ex_d, id_ex_q;
    logic [31:0] ex_alu, ex_target, ex_result, ex_store;
    logic        ex_taken;
    logic [31:0] exm_result_q, exm_store_q;
    logic [4:0]  exm_rd_q;
    logic        exm_we_q, exm_mem_read_q, exm_mem_write_q;
    logic [31:0] wb_data_q, load_data;
    logic [4:0]  wb_rd_q;
    logic        wb_we_q;
    logic [31:0] dmem [0:1023];

    assign redirect = ex_taken;
    assign load_use = id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                      ((uses_rs1 && (dec_ctrl.rs1 == id_ex_q.rd)) ||
                       (uses_rs2 && (dec_ctrl.rs2 == id_ex_q.rd)));
    assign stall    = load_use && !redirect;

    riscv_fetch fetch_stage (
        .clk        (clk),
        .rst        (rst),
        .redirect_i (redirect),
        .target_i   (ex_target),
        .stall_i    (stall),
        .pc_o       (if_pc),
        .instr_o    (if_instr)
    );

    riscv_if_id if_id_register (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (redirect),
        .hold_i          (stall),
        .instr_i         (if_instr),
        .pc_i            (if_pc),
        .instruction_out (id_instr),
        .pc_o            (id_pc)
    );

    riscv_decode decode_stage (
        .clk        (clk),
        .rst        (rst),
        .instr_i    (id_instr),
        .pc_i       (id_pc),
        .wb_we_i    (wb_we_q),
        .wb_rd_i    (wb_rd_q),
        .wb_data_i  (wb_data_q),
        .ctrl_o     (dec_ctrl),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2)
    );

    // ID/EX: a bubble is inserted on a redirect flush or a load-use stall.
    always_comb begin
        id_ex_d = (redirect || stall) ? '0 : dec_ctrl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) id_ex_q <= '0;
        else     id_ex_q <= id_ex_d;
    end

    riscv_execute execute_stage (
        .ex_i         (id_ex_q),
        .exm_we_i     (exm_we_q),
        .exm_rd_i     (exm_rd_q),
        .exm_data_i   (exm_result_q),
        .wb_we_i      (wb_we_q),
        .wb_rd_i      (wb_rd_q),
        .wb_data_i    (wb_data_q),
        .alu_result   (ex_alu),
        .branch_taken (ex_taken),
        .jump_target  (ex_target),
        .result_o     (ex_result),
        .store_data_o (ex_store)
    );

    // EX/MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exm_result_q    <= '0;
            exm_store_q     <= '0;
            exm_rd_q        <= '0;
            exm_we_q        <= 1'b0;
            exm_mem_read_q  <= 1'b0;
            exm_mem_write_q <= 1'b0;
        end else begin
            exm_result_q    <= ex_result;
            exm_store_q     <= ex_store;
            exm_rd_q        <= id_ex_q.rd;
            exm_we_q        <= id_ex_q.reg_write;
            exm_mem_read_q  <= id_ex_q.mem_read;
            exm_mem_write_q <= id_ex_q.mem_write;
        end
    end

    // Data memory: word access, synchronous store, combinational load.
    always_ff @(posedge clk) begin
        if (exm_mem_write_q) dmem[exm_result_q[11:2]] <= exm_store_q;
    end
    assign load_data = dmem[exm_result_q[11:2]];

    // MEM/WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
        end else begin
            wb_data_q <= exm_mem_read_q ? load_data : exm_result_q;
            wb_rd_q   <= exm_rd_q;
            wb_we_q   <= exm_we_q;
        end
    end

    // ex_alu is observed through execute_stage.alu_result.
    logic unused_alu;
    assign unused_alu = ^ex_alu;
endmodule

// File: tb/tb_riscv_processor.sv
// Testbench for riscv_processor: loads small programs into instruction
// memory, runs them and compares architectural state against expectations.
module tb_riscv_processor;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    riscv_processor dut (
        .clk (clk),
        .rst (rst)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          idx;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_reg(input int idx);
        return dut.decode_stage.reg_file.registers[idx];
    endfunction

    task automatic expect_reg(input string tag, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, rd_reg(e.idx), e.val);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) dut.fetch_stage.imem.mem[i] = 32'h0;
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut.fetch_stage.imem.mem[idx] = w;
    endtask

    task automatic reset_assert();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ALU sequence, back-to-back dependencies
        clear_imem();
        put(0,  enc_i(OP_I, 3'b000, 5'd1, 5'd0, 32'd5));
        put(1,  enc_i(OP_I, 3'b000, 5'd2, 5'd0, 32'd10));
        put(2,  enc_r(7'h00, 3'b000, 5'd3,  5'd1, 5'd2));
        put(3,  enc_r(7'h20, 3'b000, 5'd4,  5'd1, 5'd2));
        put(4,  enc_r(7'h00, 3'b111, 5'd5,  5'd1, 5'd2));
        put(5,  enc_r(7'h00, 3'b110, 5'd6,  5'd1, 5'd2));
        put(6,  enc_r(7'h00, 3'b100, 5'd7,  5'd1, 5'd2));
        put(7,  enc_r(7'h00, 3'b001, 5'd8,  5'd1, 5'd1));
        put(8,  enc_r(7'h00, 3'b101, 5'd9,  5'd1, 5'd2));
        put(9,  enc_r(7'h20, 3'b101, 5'd10, 5'd1, 5'd2));
        put(10, enc_r(7'h00, 3'b010, 5'd11, 5'd1, 5'd2));
        put(11, enc_r(7'h00, 3'b011, 5'd12, 5'd1, 5'd2));
        reset_assert();
        check_eq("rst_pc", dut.fetch_stage.pc, 32'd0);
        check_eq("rst_ifid", dut.if_id_register.instruction_out, NOP);
        check_eq("rst_alu", dut.execute_stage.alu_result, 32'd0);
        check_eq("rst_taken", {31'd0, dut.execute_stage.branch_taken}, 32'd0);
        check_eq("rst_target", dut.execute_stage.jump_target, 32'd0);
        expect_reg("alu_x1", 1, 32'd5);
        expect_reg("alu_x2", 2, 32'd10);
        expect_reg("alu_add", 3, 32'd15);
        expect_reg("alu_sub", 4, 32'hFFFF_FFFB);
        expect_reg("alu_and", 5, 32'd0);
        expect_reg("alu_or", 6, 32'd15);
        expect_reg("alu_xor", 7, 32'd15);
        expect_reg("alu_sll", 8, 32'd160);
        expect_reg("alu_srl", 9, 32'd0);
        expect_reg("alu_sra", 10, 32'd0);
        expect_reg("alu_slt", 11, 32'd1);
        expect_reg("alu_sltu", 12, 32'd1);
        reset_release();
        tick(4);
        check_eq("lat_x1_before", rd_reg(1), 32'd0);
        tick(1);
        check_eq("lat_x1_after", rd_reg(1), 32'd5);
        tick(20);
        drain_sb();

        // Store then load with load-use stall
        clear_imem();
        put(0, enc_i(OP_I, 3'b000, 5'd5, 5'd0, 32'd6));
        put(1, enc_sw(5'd5, 5'd0, 32'd0));
        put(2, enc_i(OP_LD, 3'b010, 5'd6, 5'd0, 32'd0));
        put(3, enc_r(7'h00, 3'b000, 5'd7, 5'd6, 5'd6));
        reset_assert();
        check_eq("rst_clr_x3", rd_reg(3), 32'd0);
        check_eq("rst_clr_x12", rd_reg(12), 32'd0);
        expect_reg("ld_x5", 5, 32'd6);
        expect_reg("ld_x6", 6, 32'd6);
        expect_reg("ld_x7", 7, 32'd12);
        reset_release();
        tick(8);
        check_eq("ld_x6_wb", rd_reg(6), 32'd6);
        check_eq("ld_stall_x7_before", rd_reg(7), 32'd0);
        tick(1);
        check_eq("ld_stall_x7_after", rd_reg(7), 32'd12);
        tick(5);
        drain_sb();

        // Branches
        clear_imem();
        put(0, enc_i(OP_I, 3'b000, 5'd1, 5'd0, 32'd5));
        put(1, enc_i(OP_I, 3'b000, 5'd2, 5'd0, 32'd10));
        put(2, enc_b(3'b000, 5'd1, 5'd2, 32'd12));
        put(3, enc_i(OP_I, 3'b000, 5'd3, 5'd0, 32'd1));
        put(4, enc_b(3'b001, 5'd1, 5'd2, 32'd12));
        put(5, enc_i(OP_I, 3'b000, 5'd4, 5'd0, 32'd1));
        put(6, enc_i(OP_I, 3'b000, 5'd5, 5'd0, 32'd1));
        put(7, enc_i(OP_I, 3'b000, 5'd6, 5'd0, 32'd1));
        reset_assert();
        expect_reg("br_x3_seq", 3, 32'd1);
        expect_reg("br_x4_squash", 4, 32'd0);
        expect_reg("br_x5_squash", 5, 32'd0);
        expect_reg("br_x6_target", 6, 32'd1);
        reset_release();
        tick(4);
        check_eq("beq_taken", {31'd0, dut.execute_stage.branch_taken}, 32'd0);
        check_eq("beq_pc_seq", dut.fetch_stage.pc, 32'd16);
        tick(2);
        check_eq("bne_taken", {31'd0, dut.execute_stage.branch_taken}, 32'd1);
        check_eq("bne_target", dut.execute_stage.jump_target, 32'd28);
        tick(1);
        check_eq("bne_pc", dut.fetch_stage.pc, 32'd28);
        tick(15);
        drain_sb();

        // Jumps (jal to next word, jalr back to word 1, looping)
        clear_imem();
        put(0, enc_i(OP_I, 3'b000, 5'd1, 5'd0, 32'd5));
        put(1, enc_jal(5'd3, 32'd4));
        put(2, enc_i(OP_JLR, 3'b000, 5'd4, 5'd1, 32'd0));
        reset_assert();
        expect_reg("jal_link", 3, 32'd8);
        expect_reg("jalr_link", 4, 32'd12);
        reset_release();
        tick(3);
        check_eq("jal_taken", {31'd0, dut.execute_stage.branch_taken}, 32'd1);
        check_eq("jal_target", dut.execute_stage.jump_target, 32'd8);
        tick(1);
        check_eq("jal_pc", dut.fetch_stage.pc, 32'd8);
        check_eq("jal_flush", dut.if_id_register.instruction_out, NOP);
        tick(2);
        check_eq("jalr_taken", {31'd0, dut.execute_stage.branch_taken}, 32'd1);
        check_eq("jalr_target", dut.execute_stage.jump_target, 32'd4);
        tick(1);
        check_eq("jalr_pc", dut.fetch_stage.pc, 32'd4);
        tick(1);
        check_eq("jalr_refetch", dut.if_id_register.instruction_out, enc_jal(5'd3, 32'd4));
        tick(12);
        drain_sb();

        // x0 write ignored, then mid-run reset, then zero-filled memory
        clear_imem();
        put(0, enc_i(OP_I, 3'b000, 5'd0, 5'd0, 32'd7));
        put(1, enc_i(OP_I, 3'b000, 5'd1, 5'd0, 32'd3));
        reset_assert();
        reset_release();
        tick(8);
        check_eq("x0_stays_zero", rd_reg(0), 32'd0);
        check_eq("x0_x1", rd_reg(1), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("midrst_pc", dut.fetch_stage.pc, 32'd0);
        check_eq("midrst_x1", rd_reg(1), 32'd0);
        check_eq("midrst_ifid", dut.if_id_register.instruction_out, NOP);
        clear_imem();
        for (int i = 1; i < 32; i++) expect_reg($sformatf("zero_x%0d", i), i, 32'd0);
        reset_release();
        tick(12);
        check_eq("zero_pc", dut.fetch_stage.pc, 32'd48);
        check_eq("zero_taken", {31'd0, dut.execute_stage.branch_taken}, 32'd0);
        drain_sb();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
